// File: rtl/mskhpc3_rnd_feeder_if.sv
// Seed-in / randomness-out bundle of the HPC3 random feeder.
// master: seed source + rnd consumer side; slave: the feeder.
//   seed_in/seed_valid/seed_ready : 32-bit seed word handshake
//   rnd/rnd_valid/rnd_ready        : W-bit mask handshake
//   reseed_req                     : seed exhausted, reload wanted
interface mskhpc3_rnd_feeder_if #(
    parameter int W = 2
);
    logic [31:0]  seed_in;
    logic         seed_valid;
    logic         seed_ready;
    logic [W-1:0] rnd;
    logic         rnd_valid;
    logic         rnd_ready;
    logic         reseed_req;

    modport master (
        output seed_in,
        output seed_valid,
        output rnd_ready,
        input  seed_ready,
        input  rnd,
        input  rnd_valid,
        input  reseed_req
    );

    modport slave (
        input  seed_in,
        input  seed_valid,
        input  rnd_ready,
        output seed_ready,
        output rnd,
        output rnd_valid,
        output reseed_req
    );
endinterface

// File: rtl/mskhpc3_rnd_feeder.sv
// xorshift64 randomness feeder for a d-share HPC3 cross-domain AND.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of
// mskhpc3_rnd_feeder_if, rnd width d*(d-1)).
module mskhpc3_rnd_feeder #(
    parameter int d       = 2,
    parameter int MAX_OUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mskhpc3_rnd_feeder_if.slave  bus
);
    localparam int hpc3rnd = d * (d - 1);

    localparam logic [63:0] ZERO_SUB = 64'h0123456789ABCDEF;
    localparam logic [15:0] CNT_LAST = 16'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        LOAD0,
        LOAD1,
        RUN,
        EXH
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] s_q, s_d;
    logic [15:0] cnt_q, cnt_d;

    logic        seed_ready;
    logic        rnd_valid;
    logic        seed_fire;
    logic        rnd_fire;
    logic [63:0] s_next;
    logic [63:0] s_loaded;

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    assign seed_fire = bus.seed_valid & seed_ready;
    assign rnd_fire  = bus.rnd_ready & rnd_valid;
    assign s_next    = xs(s_q);

    // Zero is a fixed point of xorshift; substitute a constant.
    assign s_loaded = ({bus.seed_in, s_q[31:0]} == 64'd0)
                    ? ZERO_SUB
                    : {bus.seed_in, s_q[31:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD0;
            s_q     <= 64'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LOAD0, EXH: begin
                if (seed_fire) begin
                    s_d     = {32'd0, bus.seed_in};
                    state_d = LOAD1;
                end
            end
            LOAD1: begin
                if (seed_fire) begin
                    s_d     = s_loaded;
                    cnt_d   = 16'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rnd_fire) begin
                    s_d   = s_next;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = EXH;
                    end
                end
            end
            default: begin
                state_d = LOAD0;
            end
        endcase
    end

    always_comb begin
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        unique case (state_q)
            LOAD0, LOAD1: seed_ready = 1'b1;
            RUN:          rnd_valid  = 1'b1;
            EXH:          seed_ready = 1'b1;
            default:      seed_ready = 1'b0;
        endcase
    end

    assign bus.seed_ready = seed_ready;
    assign bus.rnd_valid  = rnd_valid;
    assign bus.reseed_req = (state_q == EXH);
    assign bus.rnd        = s_q[hpc3rnd-1:0];

endmodule

// File: tb/tb_mskhpc3_rnd_feeder.sv
// Bench for mskhpc3_rnd_feeder: two instances (d=8 and d=2)
// driven in lockstep, checked against a per-instance model.
module tb_mskhpc3_rnd_feeder;
    localparam int WA = 56;
    localparam int WB = 2;
    localparam int MA = 7;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] seed_in = '0;
    logic seed_valid = 1'b0;
    logic rnd_ready = 1'b0;

    always #5 clk = ~clk;

    mskhpc3_rnd_feeder_if #(.W(WA)) bus_a ();
    mskhpc3_rnd_feeder_if #(.W(WB)) bus_b ();

    assign bus_a.seed_in    = seed_in;
    assign bus_a.seed_valid = seed_valid;
    assign bus_a.rnd_ready  = rnd_ready;
    assign bus_b.seed_in    = seed_in;
    assign bus_b.seed_valid = seed_valid;
    assign bus_b.rnd_ready  = rnd_ready;

    mskhpc3_rnd_feeder #(.d(8), .MAX_OUT(MA)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    mskhpc3_rnd_feeder #(.d(2), .MAX_OUT(MB)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: phase 0 wait low word, 1 wait high word, 2 run, 3 spent
    logic [63:0] m_s[2];
    int          m_ph[2];
    int          m_n[2];
    int          m_max[2];
    int          m_w[2];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    function automatic logic [63:0] mrnd(int k);
        logic [63:0] mask;
        mask = (64'd1 << m_w[k]) - 64'd1;
        return m_s[k] & mask;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ph[k] = 0;
                m_s[k]  = 64'd0;
                m_n[k]  = 0;
            end else if ((m_ph[k] == 0 || m_ph[k] == 3) && seed_valid) begin
                m_s[k]  = {32'd0, seed_in};
                m_ph[k] = 1;
            end else if (m_ph[k] == 1 && seed_valid) begin
                m_s[k] = {seed_in, m_s[k][31:0]};
                if (m_s[k] == 64'd0) m_s[k] = 64'h0123456789ABCDEF;
                m_n[k]  = 0;
                m_ph[k] = 2;
            end else if (m_ph[k] == 2 && rnd_ready) begin
                m_s[k] = xs(m_s[k]);
                m_n[k]++;
                if (m_n[k] == m_max[k]) m_ph[k] = 3;
            end
        end
    endtask

    task automatic cmp_all();
        chk("a_rnd", {8'd0, bus_a.rnd}, mrnd(0));
        chk("a_srdy", {63'd0, bus_a.seed_ready}, {63'd0, m_ph[0] != 2});
        chk("a_rvld", {63'd0, bus_a.rnd_valid}, {63'd0, m_ph[0] == 2});
        chk("a_rsq", {63'd0, bus_a.reseed_req}, {63'd0, m_ph[0] == 3});
        chk("b_rnd", {62'd0, bus_b.rnd}, mrnd(1));
        chk("b_srdy", {63'd0, bus_b.seed_ready}, {63'd0, m_ph[1] != 2});
        chk("b_rvld", {63'd0, bus_b.rnd_valid}, {63'd0, m_ph[1] == 2});
        chk("b_rsq", {63'd0, bus_b.reseed_req}, {63'd0, m_ph[1] == 3});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic drive(logic r, logic sv, logic [31:0] sd, logic rr);
        rst_n      = r;
        seed_valid = sv;
        seed_in    = sd;
        rnd_ready  = rr;
        cyc();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic load(logic [31:0] lo, logic [31:0] hi);
        drive(1'b1, 1'b1, lo, 1'b0);
        drive(1'b1, 1'b1, hi, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    logic [63:0] held;

    initial begin
        m_max[0] = MA;
        m_max[1] = MB;
        m_w[0]   = WA;
        m_w[1]   = WB;
        for (int k = 0; k < 2; k++) begin
            m_s[k]  = 64'd0;
            m_ph[k] = 0;
            m_n[k]  = 0;
        end

        // reset state
        do_reset();
        chk("rst_rnd", {8'd0, bus_a.rnd}, 64'd0);
        chk("rst_srdy", {63'd0, bus_a.seed_ready}, 64'd1);
        chk("rst_rsq", {63'd0, bus_b.reseed_req}, 64'd0);

        // d=8: seed 1,0 -> rnd 1, then one xorshift step
        load(32'h0000_0001, 32'h0000_0000);
        chk("s1_rnd0", {8'd0, bus_a.rnd}, 64'h1);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        chk("s1_rnd1", {8'd0, bus_a.rnd}, 64'h40822041);

        // all-zero seed substitutes the constant
        do_reset();
        load(32'd0, 32'd0);
        chk("s2_rnd_b", {62'd0, bus_b.rnd}, 64'd3);
        chk("s2_rnd_a", {8'd0, bus_a.rnd}, 64'h0023456789ABCDEF);
        chk("s2_rsq", {63'd0, bus_b.reseed_req}, 64'd0);

        // stall holds the word; next handshake gives xs(held)
        held = 64'h0123456789ABCDEF;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0);
            chk("s3_hold", {8'd0, bus_a.rnd}, held & 64'h00FF_FFFF_FFFF_FFFF);
            chk("s3_vld", {63'd0, bus_a.rnd_valid}, 64'd1);
        end
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("s3_next", {8'd0, bus_a.rnd}, xs(held) & 64'h00FF_FFFF_FFFF_FFFF);

        // exhaustion of the MAX_OUT=4 instance and reload
        do_reset();
        load(32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < MB; i++) drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("s4_rsq", {63'd0, bus_b.reseed_req}, 64'd1);
        chk("s4_vld", {63'd0, bus_b.rnd_valid}, 64'd0);
        chk("s4_srdy", {63'd0, bus_b.seed_ready}, 64'd1);
        load(32'hCAFE_F00D, 32'h0BAD_BEEF);
        chk("s4_run", {63'd0, bus_b.rnd_valid}, 64'd1);
        for (int i = 0; i < MB - 1; i++) drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("s4_cnt0", {63'd0, bus_b.rnd_valid}, 64'd1);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        chk("s4_exh2", {63'd0, bus_b.reseed_req}, 64'd1);

        // reset mid-load discards the partial seed
        do_reset();
        drive(1'b1, 1'b1, 32'h5555_AAAA, 1'b0);
        do_reset();
        chk("s5_rnd", {8'd0, bus_a.rnd}, 64'd0);
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("s5_lo", {8'd0, bus_a.rnd}, 64'hDEAD_BEEF);
        chk("s5_srdy", {63'd0, bus_a.seed_ready}, 64'd1);

        // seed words offered during RUN are ignored
        drive(1'b1, 1'b1, 32'h0000_0007, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, $urandom, i[0]);
            chk("s6_srdy", {63'd0, bus_a.seed_ready}, 64'd0);
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) != 0),
                  (($urandom_range(0, 9) == 0) ? 32'd0 : $urandom),
                  ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mskhpc3_rnd_feeder.md
MSKHPC3_RND_FEEDER -- requirements
Module: mskhpc3_rnd_feeder

Interface
REQ-001 Parameter d, default 2 (`DEFAULTSHARES`), is the share count of the consuming HPC3 cross-domain AND; legal range is 2..8.
REQ-002 Parameter MAX_OUT, default 1024, is the number of random words delivered per seed; legal range is 2..65535.
REQ-003 Localparam hpc3rnd is d*(d-1): two d(d-1)/2-bit blocks for the gadget's rnd0 and rnd1 halves.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-low, rst_n.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- seed_in  in  32  seed word.
- seed_valid  in  1  seed word is offered.
- seed_ready  out  1  block accepts a seed word.
- rnd  out  hpc3rnd  fresh randomness, wired bit-for-bit to the gadget's rnd input.
- rnd_valid  out  1  rnd holds a fresh value.
- rnd_ready  in  1  consumer takes rnd this cycle.
- reseed_req  out  1  the seed is exhausted.

Function
REQ-006 Internal state SHALL be a 64-bit register S, a counter cnt of 16 bits, and an FSM with states LOAD0, LOAD1, RUN and EXH.
REQ-007 The seed handshake fires on a cycle when seed_valid=1 and seed_ready=1; the output handshake fires on a cycle when rnd_valid=1 and rnd_ready=1.
REQ-008 seed_ready SHALL be 1 exactly in LOAD0, LOAD1 and EXH; rnd_valid SHALL be 1 exactly in RUN; reseed_req SHALL be 1 exactly in EXH; all three are decoded directly from registered state.
REQ-009 In LOAD0 or EXH, a seed handshake SHALL load S[31:0] from seed_in, clear S[63:32] and go to LOAD1; with no handshake the state is held.
REQ-010 In LOAD1, a seed handshake SHALL load S[63:32] from seed_in, clear cnt and go to RUN.
REQ-011 If S is all-zero at the LOAD1 to RUN transition, S SHALL be loaded with 64'h0123456789ABCDEF instead, since zero is a fixed point of the generator.
REQ-012 rnd SHALL equal S[hpc3rnd-1:0] combinationally from the register, with no additional latency.
REQ-013 In RUN, each output handshake SHALL replace S with xs(S), where xs is applied in order:
- x ^= x<<13
- x ^= x>>7
- x ^= x<<17
- all operations are 64-bit logical, discarding overflow.
REQ-014 In RUN, each output handshake SHALL increment cnt; when cnt = MAX_OUT-1 at the handshake, the next state SHALL be EXH (S is still updated).
REQ-015 In RUN with rnd_ready=0, S, cnt and rnd SHALL hold, so a word is never skipped or repeated across a stall.
REQ-016 seed_valid in RUN SHALL be ignored, and no seed word is consumed.
REQ-017 rnd_ready outside RUN SHALL be ignored, and S is unchanged.
REQ-018 Each rnd value SHALL be presented for exactly one output handshake, so the gadget never receives the same mask twice.
REQ-019 Changing seed_in while seed_valid=1 and seed_ready=0 SHALL have no effect.

Reset
REQ-020 With rst_n=0 at a rising clk edge, the block SHALL set state=LOAD0, S=0 and cnt=0, giving seed_ready=1, rnd_valid=0, reseed_req=0 and rnd=0 on the next cycle.
REQ-021 Reset SHALL take priority over every handshake, including reset mid-seed-load or in RUN; a partially loaded seed is discarded.
REQ-022 No output SHALL be X after the first reset edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Scenario 1, d=8: after reset, seed words 0x00000001 then 0x00000000 -> RUN; rnd=56'h1; after one output handshake rnd=56'h40822041.
- Scenario 2, d=2: seed words 0, 0 -> S=64'h0123456789ABCDEF; rnd=2'b11; reseed_req=0.
- Scenario 3: in RUN, hold rnd_ready=0 for 5 cycles -> rnd is stable and rnd_valid=1; the next handshake yields xs of the held S.
- Scenario 4, MAX_OUT=4: after 4 handshakes -> EXH, with rnd_valid=0, reseed_req=1, seed_ready=1; two new seed words -> RUN, cnt=0.
- Scenario 5: assert rst_n=0 after only the first seed word -> LOAD0 with S=0; the next word accepted loads S[31:0].
- Scenario 6: seed_valid=1 during RUN -> seed_ready=0, S is unaffected, and the rnd sequence matches the reference model.
